multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
//  Multi-cycle control unit for the 16-bit processor. It sequences fetch, decode, execute,
//  memory and writeback, and drives the datapath selects: ALUSrcA/B, ALUOp, PCSrc and the
//  write strobes. It consumes the IR contents, the ALU zero/negative flags and the memory
//  ready handshake. It is the controlling side of the calculation-stage interface.
// PARAMETERS
//  WAIT_TIMEOUT  255  max consecutive mem_ready=0 cycles tolerated in a wait state
//  CNT_W         8    timeout counter width; must hold WAIT_TIMEOUT
// PORTS
//  clk          in   1   single clock; all state updates on rising edge
//  rst_n        in   1   asynchronous, active-low reset
//  instr        in   16  IR contents; opcode=instr[15:12], funct=instr[2:0]
//  zero         in   1   ALU zero flag, combinational from ALU, same cycle
//  negative     in   1   ALU negative flag, combinational, same cycle
//  mem_ready    in   1   memory completes the current read/write this cycle
//  alu_src_a    out  2   0=PC 1=const 2 2=A reg 3=imm
//  alu_src_b    out  2   0=B reg 1=const 2 2=imm
//  alu_op       out  3   000 add, 001 sub, 010 and, 011 or, others per ALU
//  pc_src       out  1   0=ALU result direct, 1=ALUOut register
//  pc_write     out  1   PC load strobe
//  ir_write     out  1   IR load strobe
//  mem_read     out  1   memory read request
//  mem_write    out  1   memory write request
//  i_or_d       out  1   address select: 0=PC, 1=ALUOut
//  reg_write    out  1   register file write strobe
//  reg_dst      out  1   0=rt field, 1=rd field
//  mem_to_reg   out  2   writeback data: 0=ALUOut 1=MDR 2=PC
//  halted       out  1   high while in HALT
//  timeout_err  out  1   sticky; set when HALT was entered by timeout
//  state        out  4   current state encoding (debug)
// BEHAVIOUR
//  - rst_n=0: state<=IDLE, counter<=0, timeout_err<=0, immediately. All outputs 0 while in reset.
//  - Encodings: IDLE 0, FETCH 1, DECODE 2, MEM_ADDR 3, MEM_RD 4, MEM_WB 5, MEM_WR 6, EXEC_R 7,
//    EXEC_I 8, ALU_WB 9, BRANCH 10, JUMP 11, HALT 15.
//  - Outputs are Moore-style decodes of the state. Any output not listed for a state is 0.
//  - IDLE: all 0; always moves to FETCH the next cycle.
//  - FETCH: mem_read=1, alu_src_a=0, alu_src_b=1, alu_op=add, pc_src=0.
//    ir_write and pc_write=mem_ready. Exits to DECODE only on mem_ready=1.
//  - DECODE: alu_src_a=0, alu_src_b=2, add; this places the PC+2+imm target in ALUOut.
//    Next state by opcode: 0000 EXEC_R; 0001 EXEC_I; 0010/0011 MEM_ADDR;
//    0100 beq, 0101 bne, 0110 blt -> BRANCH; 0111 j, 1000 jal -> JUMP; all others -> HALT.
//  - EXEC_R: src_a=2, src_b=0, alu_op=funct. EXEC_I: src_a=2, src_b=2, add. Both go to ALU_WB.
//  - ALU_WB: reg_write=1, mem_to_reg=0, reg_dst=1 for R-type and 0 for addi; then FETCH.
//  - MEM_ADDR: src_a=2, src_b=2, add. Goes to MEM_RD for lw, MEM_WR for sw.
//  - MEM_RD: i_or_d=1, mem_read=1; on mem_ready goes to MEM_WB.
//    MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0; then FETCH.
//  - MEM_WR: i_or_d=1, mem_write=1; on mem_ready goes to FETCH.
//  - BRANCH: src_a=2, src_b=0, sub, pc_src=1. pc_write is zero (beq), !zero (bne) or
//    negative (blt), evaluated the same cycle; then FETCH.
//  - JUMP: pc_src=1, pc_write=1. For jal also reg_write=1, mem_to_reg=2, reg_dst=0; then FETCH.
//  - Timeout: the counter clears on entry to FETCH, MEM_RD or MEM_WR, and increments on each
//    cycle there with mem_ready=0. When it reaches WAIT_TIMEOUT with mem_ready=0 the next
//    state is HALT and timeout_err<=1. mem_ready=1 on that same cycle wins: normal exit.
//  - HALT: halted=1, all strobes 0; stays until rst_n. An illegal opcode leaves timeout_err=0.
//  - Latencies (FETCH to FETCH, mem_ready=1): R/addi 4, lw 5, sw 4, branch/jump 3.
// TESTING
//  - Reset asserted during MEM_RD -> all outputs 0 same cycle; release -> IDLE 1 cycle, then FETCH.
//  - FETCH with mem_ready=0 for 3 cycles -> ir_write/pc_write=1 only on cycle 4; src_a=0, src_b=1.
//  - instr=0x0001 (R sub) -> EXEC_R alu_op=001 src_a=2 src_b=0; ALU_WB reg_write=1 reg_dst=1.
//  - beq 0x4000: zero=1 -> pc_write=1 pc_src=1; zero=0 -> pc_write=0. blt with negative=1 -> pc_write=1.
//  - lw, WAIT_TIMEOUT=4, mem_ready=0 in MEM_RD -> HALT, halted=1, timeout_err=1, held until rst_n.
//  - instr=0xA000 -> DECODE then HALT, timeout_err=0. jal 0x8000 -> reg_write=1 mem_to_reg=2.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control unit for the 16-bit processor: sequences fetch/decode/execute/memory/
// writeback and drives datapath selects and strobes as Moore decodes of the state register.
module multicycle_control_fsm #(
  parameter int WAIT_TIMEOUT = 255,
  parameter int CNT_W        = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] instr,
  input  logic        zero,
  input  logic        negative,
  input  logic        mem_ready,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  alu_op,
  output logic        pc_src,
  output logic        pc_write,
  output logic        ir_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        i_or_d,
  output logic        reg_write,
  output logic        reg_dst,
  output logic [1:0]  mem_to_reg,
  output logic        halted,
  output logic        timeout_err,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    MEM_ADDR = 4'd3,
    MEM_RD   = 4'd4,
    MEM_WB   = 4'd5,
    MEM_WR   = 4'd6,
    EXEC_R   = 4'd7,
    EXEC_I   = 4'd8,
    ALU_WB   = 4'd9,
    BRANCH   = 4'd10,
    JUMP     = 4'd11,
    HALT     = 4'd15
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;

  state_t           cur, nxt;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       opcode;
  logic             in_wait, timed_out;
  logic             unused_bits;

  assign opcode      = instr[15:12];
  assign unused_bits = ^instr[11:3];
  assign state       = cur;

  assign in_wait   = (cur == FETCH) || (cur == MEM_RD) || (cur == MEM_WR);
  // mem_ready on the limit cycle still completes normally; only a further stall halts.
  assign timed_out = in_wait && !mem_ready && (cnt == CNT_W'(WAIT_TIMEOUT));

  always_comb begin
    nxt = cur;
    case (cur)
      IDLE:     nxt = FETCH;
      FETCH:    if (mem_ready) nxt = DECODE; else if (timed_out) nxt = HALT;
      DECODE: begin
        case (opcode)
          4'd0:                nxt = EXEC_R;
          4'd1:                nxt = EXEC_I;
          4'd2, 4'd3:          nxt = MEM_ADDR;
          4'd4, 4'd5, 4'd6:    nxt = BRANCH;
          4'd7, 4'd8:          nxt = JUMP;
          default:             nxt = HALT;
        endcase
      end
      EXEC_R, EXEC_I: nxt = ALU_WB;
      MEM_ADDR: nxt = (opcode == 4'd3) ? MEM_WR : MEM_RD;
      MEM_RD:   if (mem_ready) nxt = MEM_WB; else if (timed_out) nxt = HALT;
      MEM_WR:   if (mem_ready) nxt = FETCH;  else if (timed_out) nxt = HALT;
      ALU_WB, MEM_WB, BRANCH, JUMP: nxt = FETCH;
      HALT:     nxt = HALT;
      default:  nxt = HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur         <= IDLE;
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      cur <= nxt;
      cnt <= (in_wait && !mem_ready) ? cnt + CNT_W'(1) : '0;
      if (timed_out) timeout_err <= 1'b1;
    end
  end

  always_comb begin
    alu_src_a  = 2'd0;
    alu_src_b  = 2'd0;
    alu_op     = OP_ADD;
    pc_src     = 1'b0;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 2'd0;
    halted     = 1'b0;
    case (cur)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      DECODE:   alu_src_b = 2'd2;
      MEM_ADDR: begin alu_src_a = 2'd2; alu_src_b = 2'd2; end
      MEM_RD:   begin i_or_d = 1'b1; mem_read = 1'b1; end
      MEM_WB:   begin reg_write = 1'b1; mem_to_reg = 2'd1; end
      MEM_WR:   begin i_or_d = 1'b1; mem_write = 1'b1; end
      EXEC_R:   begin alu_src_a = 2'd2; alu_op = instr[2:0]; end
      EXEC_I:   begin alu_src_a = 2'd2; alu_src_b = 2'd2; end
      ALU_WB: begin
        reg_write = 1'b1;
        reg_dst   = (opcode == 4'd0);
      end
      BRANCH: begin
        alu_src_a = 2'd2;
        alu_op    = OP_SUB;
        pc_src    = 1'b1;
        case (opcode)
          4'd4:    pc_write = zero;
          4'd5:    pc_write = !zero;
          default: pc_write = negative;
        endcase
      end
      JUMP: begin
        pc_src   = 1'b1;
        pc_write = 1'b1;
        if (opcode == 4'd8) begin
          reg_write  = 1'b1;
          mem_to_reg = 2'd2;
        end
      end
      HALT:    halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: directed scenarios plus random instruction streams,
// checked against per-instruction expected state paths and per-state output rules.
module tb_multicycle_control_fsm;

  localparam int WT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] instr = 16'h0;
  logic        zero = 1'b0, negative = 1'b0, mem_ready = 1'b0;
  logic [1:0]  alu_src_a, alu_src_b, mem_to_reg;
  logic [2:0]  alu_op;
  logic        pc_src, pc_write, ir_write, mem_read, mem_write, i_or_d;
  logic        reg_write, reg_dst, halted, timeout_err;
  logic [3:0]  state;

  int n_checks = 0;
  int n_fails  = 0;
  logic exp_terr = 1'b0;

  multicycle_control_fsm #(.WAIT_TIMEOUT(WT), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero), .negative(negative),
    .mem_ready(mem_ready), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_src(pc_src), .pc_write(pc_write), .ir_write(ir_write), .mem_read(mem_read),
    .mem_write(mem_write), .i_or_d(i_or_d), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .halted(halted), .timeout_err(timeout_err), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [17:0] obs;
  assign obs = {alu_src_a, alu_src_b, alu_op, pc_src, pc_write, ir_write, mem_read,
                mem_write, i_or_d, reg_write, reg_dst, mem_to_reg, halted};

  // Spec output rules per named state; anything not listed stays 0.
  function automatic logic [17:0] exp_out(input int code, input logic [15:0] ins,
                                          input logic z, input logic n, input logic mr);
    logic [1:0] sa, sb, mtr;
    logic [2:0] op;
    logic pcs, pcw, irw, mrd, mwr, iod, rw, rd, hlt;
    logic [3:0] opc;
    opc = ins[15:12];
    {sa, sb, mtr, op, pcs, pcw, irw, mrd, mwr, iod, rw, rd, hlt} = '0;
    case (code)
      1:  begin mrd = 1; sb = 1; pcw = mr; irw = mr; end
      2:  sb = 2;
      3:  begin sa = 2; sb = 2; end
      4:  begin iod = 1; mrd = 1; end
      5:  begin rw = 1; mtr = 1; end
      6:  begin iod = 1; mwr = 1; end
      7:  begin sa = 2; op = ins[2:0]; end
      8:  begin sa = 2; sb = 2; end
      9:  begin rw = 1; rd = (opc == 4'd0); end
      10: begin
        sa = 2; op = 3'b001; pcs = 1;
        pcw = (opc == 4'd4) ? z : (opc == 4'd5) ? !z : n;
      end
      11: begin pcs = 1; pcw = 1; if (opc == 4'd8) begin rw = 1; mtr = 2; end end
      15: hlt = 1;
      default: ;
    endcase
    return {sa, sb, op, pcs, pcw, irw, mrd, mwr, iod, rw, rd, mtr, hlt};
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_checks++;
    assert (o === e) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic cyc(input int code, input logic mr, input logic z, input logic n);
    @(negedge clk);
    mem_ready = mr; zero = z; negative = n;
    #1;
    chk($sformatf("state@%0d", code), {28'd0, state}, code);
    chk($sformatf("outs@%0d", code), {14'd0, obs}, {14'd0, exp_out(code, instr, z, n, mr)});
    chk("timeout_err", {31'd0, timeout_err}, {31'd0, exp_terr});
  endtask

  function automatic logic rb();
    return logic'($urandom_range(0, 1));
  endfunction

  // Runs one instruction from FETCH until the cycle before the next FETCH.
  task automatic run_instr(input logic [15:0] ins, input int fw, input int mw,
                           input logic z, input logic n);
    int op;
    instr = ins;
    op = int'(ins[15:12]);
    for (int i = 0; i < fw; i++) cyc(1, 1'b0, rb(), rb());
    cyc(1, 1'b1, rb(), rb());
    cyc(2, rb(), rb(), rb());
    case (op)
      0:  begin cyc(7, rb(), rb(), rb()); cyc(9, rb(), rb(), rb()); end
      1:  begin cyc(8, rb(), rb(), rb()); cyc(9, rb(), rb(), rb()); end
      2: begin
        cyc(3, rb(), rb(), rb());
        for (int i = 0; i < mw; i++) cyc(4, 1'b0, rb(), rb());
        cyc(4, 1'b1, rb(), rb());
        cyc(5, rb(), rb(), rb());
      end
      3: begin
        cyc(3, rb(), rb(), rb());
        for (int i = 0; i < mw; i++) cyc(6, 1'b0, rb(), rb());
        cyc(6, 1'b1, rb(), rb());
      end
      4, 5, 6: cyc(10, rb(), z, n);
      7, 8:    cyc(11, rb(), rb(), rb());
      default: cyc(15, rb(), rb(), rb());
    endcase
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    cyc(0, rb(), rb(), rb());
  endtask

  initial begin
    logic [3:0] ops [9];
    ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};

    // Reset state
    #1;
    chk("reset_state", {28'd0, state}, 0);
    chk("reset_outs", {14'd0, obs}, 0);
    chk("reset_terr", {31'd0, timeout_err}, 0);
    repeat (2) @(posedge clk);
    release_reset();

    // Directed instructions
    run_instr(16'h0001, 3, 0, 1'b0, 1'b0);   // R sub, 3 fetch stalls
    run_instr(16'h0002, 0, 0, 1'b0, 1'b0);   // R and
    run_instr(16'h1234, 0, 0, 1'b0, 1'b0);   // addi
    run_instr(16'h2000, 0, 2, 1'b0, 1'b0);   // lw
    run_instr(16'h2000, 0, WT, 1'b0, 1'b0);  // lw, ready on the limit cycle
    run_instr(16'h3000, WT, 1, 1'b0, 1'b0);  // sw
    run_instr(16'h4000, 0, 0, 1'b1, 1'b0);   // beq taken
    run_instr(16'h4000, 0, 0, 1'b0, 1'b1);   // beq not taken
    run_instr(16'h5000, 0, 0, 1'b0, 1'b0);   // bne taken
    run_instr(16'h6000, 0, 0, 1'b0, 1'b1);   // blt taken
    run_instr(16'h6000, 0, 0, 1'b1, 1'b0);   // blt not taken
    run_instr(16'h7000, 0, 0, 1'b0, 1'b0);   // j
    run_instr(16'h8000, 0, 0, 1'b0, 1'b0);   // jal

    // Random legal instruction stream
    for (int k = 0; k < 60; k++) begin
      logic [15:0] ins;
      ins = {ops[$urandom_range(0, 8)], 12'($urandom)};
      run_instr(ins, $urandom_range(0, WT), $urandom_range(0, WT), rb(), rb());
    end

    // lw with memory never ready -> timeout halt
    instr = 16'h2000;
    cyc(1, 1'b1, 1'b0, 1'b0);
    cyc(2, 1'b0, 1'b0, 1'b0);
    cyc(3, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i <= WT; i++) cyc(4, 1'b0, rb(), rb());
    exp_terr = 1'b1;
    for (int i = 0; i < 4; i++) cyc(15, rb(), rb(), rb());

    // Reset out of HALT, then reset asserted mid MEM_RD
    @(negedge clk);
    rst_n = 1'b0;
    exp_terr = 1'b0;
    #1;
    chk("halt_reset_terr", {31'd0, timeout_err}, 0);
    release_reset();
    instr = 16'h2000;
    cyc(1, 1'b1, 1'b0, 1'b0);
    cyc(2, 1'b0, 1'b0, 1'b0);
    cyc(3, 1'b0, 1'b0, 1'b0);
    cyc(4, 1'b0, 1'b0, 1'b0);
    mem_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_state", {28'd0, state}, 0);
    chk("rst_mid_outs", {14'd0, obs}, 0);
    chk("rst_mid_terr", {31'd0, timeout_err}, 0);
    release_reset();

    // Illegal opcode halts without timeout flag
    run_instr(16'hA000, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(15, rb(), rb(), rb());

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
